// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle of the ID->EX handshake, the hazard-unit controls and
//               the EX-side fields returned to the hazard unit and MEM.
//               The slave modport is the EX pipeline register; the master
//               modport is the producer side (decode, hazard unit, MEM).
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int PAYLOAD_W = 128
);
    // Producer side: decode stage, hazard unit, MEM stage
    logic                 id_valid_out;
    logic                 id_ready_go;
    logic                 ex_flush;
    logic [PAYLOAD_W-1:0] id_payload;
    logic [4:0]           id_rd_no;
    logic                 id_mem_read;
    logic                 id_reg_write_en;
    logic                 id_multicycle;
    logic                 mem_allow_in;

    // EX pipeline register side
    logic                 ex_allow_in;
    logic                 ex_valid_out;
    logic [PAYLOAD_W-1:0] ex_payload;
    logic [4:0]           ex_rd_no;
    logic                 ex_mem_read;
    logic                 ex_reg_write_en;
    logic                 ex_busy;

    modport slave (
        input  id_valid_out, id_ready_go, ex_flush, id_payload, id_rd_no,
               id_mem_read, id_reg_write_en, id_multicycle, mem_allow_in,
        output ex_allow_in, ex_valid_out, ex_payload, ex_rd_no,
               ex_mem_read, ex_reg_write_en, ex_busy
    );

    modport master (
        output id_valid_out, id_ready_go, ex_flush, id_payload, id_rd_no,
               id_mem_read, id_reg_write_en, id_multicycle, mem_allow_in,
        input  ex_allow_in, ex_valid_out, ex_payload, ex_rd_no,
               ex_mem_read, ex_reg_write_en, ex_busy
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID->EX pipeline register with valid/allow_in handshake.
//               Multi-cycle ops are held in EX for MC_LAT cycles by an
//               occupancy counter that back-pressures ID. Hazard-visible
//               fields are forced to zero while EX is empty.
//               Optional macro EX_PERF_CNT_EN adds stall/bubble counters.
//               CNT_W must satisfy 2**CNT_W > MC_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int PAYLOAD_W = 128,
    parameter int MC_LAT    = 4,
    parameter int CNT_W     = 4
) (
    input  wire            aclk,
    input  wire            resetn,
    id_ex_stage_if.slave   bus
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]    ex_stall_cycles,
    output logic [31:0]    ex_bubble_cycles
`endif
);

    // Value loaded into the counter for a multi-cycle op; MC_LAT==1 means
    // the op finishes like a single-cycle one.
    localparam logic [CNT_W-1:0] c_MC_LOAD = (MC_LAT > 1) ? CNT_W'(MC_LAT - 1) : '0;

    logic                 r_valid;
    logic [CNT_W-1:0]     r_cnt;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [4:0]           r_rd_no;
    logic                 r_mem_read;
    logic                 r_reg_write_en;

    logic                 w_ready_go;
    logic                 w_valid_out;
    logic                 w_allow_in;
    logic                 w_accept;

    assign w_ready_go  = (r_cnt == '0);
    assign w_valid_out = r_valid & w_ready_go;
    assign w_allow_in  = ~r_valid | (w_ready_go & bus.mem_allow_in);
    assign w_accept    = bus.id_valid_out & bus.id_ready_go & w_allow_in & ~bus.ex_flush;

    // Valid bit: flush wins; otherwise refill (or bubble) whenever EX can accept
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else if (bus.ex_flush) begin
            r_valid <= 1'b0;
        end else if (w_allow_in) begin
            r_valid <= bus.id_valid_out & bus.id_ready_go;
        end
    end

    // Instruction fields capture only on a real accept and otherwise hold
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_payload      <= '0;
            r_rd_no        <= '0;
            r_mem_read     <= 1'b0;
            r_reg_write_en <= 1'b0;
        end else if (w_accept) begin
            r_payload      <= bus.id_payload;
            r_rd_no        <= bus.id_rd_no;
            r_mem_read     <= bus.id_mem_read;
            r_reg_write_en <= bus.id_reg_write_en;
        end
    end

    // Occupancy counter: load on accept, count down while occupied, clear on flush
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (bus.ex_flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= bus.id_multicycle ? c_MC_LOAD : '0;
        end else if (r_valid && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign bus.ex_allow_in     = w_allow_in;
    assign bus.ex_valid_out    = w_valid_out;
    assign bus.ex_payload      = r_payload;
    // An empty EX must never look like a producer of a real register
    assign bus.ex_rd_no        = r_valid ? r_rd_no : 5'd0;
    assign bus.ex_mem_read     = r_valid & r_mem_read;
    assign bus.ex_reg_write_en = r_valid & r_reg_write_en;
    assign bus.ex_busy         = r_valid & (r_cnt != '0);

`ifdef EX_PERF_CNT_EN
    logic r_unused_perf;
    // Stall and bubble occupancy counters, free-running with wrap-around
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            ex_stall_cycles  <= '0;
            ex_bubble_cycles <= '0;
        end else begin
            if ((r_valid & ~w_valid_out) | (r_valid & w_valid_out & ~bus.mem_allow_in)) begin
                ex_stall_cycles <= ex_stall_cycles + 32'd1;
            end
            if (~r_valid & ~bus.ex_flush) begin
                ex_bubble_cycles <= ex_bubble_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID-to-EX pipeline register with a valid/allow_in handshake, placed between decode and execute.
- Consumes the decode-stage write enable and the execute-stage flush produced by the hazard unit.
- Produces the EX-stage valid, allow_in and hazard-visible register fields that the hazard unit consumes.
- Holds multi-cycle operations (mul/div class) in EX for a fixed latency. During that time it back-pressures ID.

Parameters:
- PAYLOAD_W, 128: width of the opaque decoded-instruction bundle carried ID to EX.
- MC_LAT, 4: cycles a multi-cycle op occupies EX. Legal range 1..15; 1 means single-cycle.
- CNT_W, 4: width of the occupancy counter; must satisfy 2^CNT_W > MC_LAT.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- id_valid_out  in  1  ID holds a valid instruction.
- id_ready_go  in  1  hazard-unit decode write enable; 0 = ID stalled.
- ex_flush  in  1  hazard-unit execute flush; kills the EX contents.
- id_payload  in  PAYLOAD_W  decoded bundle.
- id_rd_no  in  5  destination GPR.
- id_mem_read  in  1  instruction is a load.
- id_reg_write_en  in  1  instruction writes a GPR.
- id_multicycle  in  1  instruction needs MC_LAT cycles in EX.
- mem_allow_in  in  1  MEM stage can accept.
- ex_allow_in  out  1  EX can accept from ID.
- ex_valid_out  out  1  EX holds a valid, finished instruction for MEM.
- ex_payload  out  PAYLOAD_W  registered bundle.
- ex_rd_no  out  5  registered rd; 0 when EX is empty.
- ex_mem_read  out  1  registered load flag; 0 when EX is empty.
- ex_reg_write_en  out  1  registered write flag; 0 when EX is empty.
- ex_busy  out  1  multi-cycle op still counting.

Behaviour:
- Reset (resetn=0, asynchronous):
  - valid=0, cnt=0, payload=0, rd=0.
  - All outputs 0 except ex_allow_in=1.
- Derived signals (all combinational):
  - ex_ready_go = (cnt==0).
  - ex_valid_out = valid & ex_ready_go.
  - ex_allow_in = ~valid | (ex_ready_go & mem_allow_in).
  - ex_busy = valid & (cnt!=0).
- Accept = id_valid_out & id_ready_go & ex_allow_in & ~ex_flush.
- Valid register:
  - ex_flush=1 → valid<=0. Flush overrides accept, hold and drain.
  - else if ex_allow_in → valid<=id_valid_out & id_ready_go, inserting a bubble when ID is stalled.
  - else hold.
- Payload, rd, mem_read, reg_write load only on Accept; otherwise they hold. No load on flush.
- Counter:
  - On Accept with id_multicycle=1 and MC_LAT>1 → cnt<=MC_LAT-1.
  - On Accept otherwise → cnt<=0.
  - While valid & cnt!=0 → decrement by 1 per cycle.
  - ex_flush → cnt<=0 immediately, including a flush mid-count.
- Latency:
  - Single-cycle op: ex_valid_out rises the cycle after Accept.
  - Multi-cycle op: ex_valid_out rises MC_LAT cycles after Accept.
- Hazard-visible outputs (ex_rd_no, ex_mem_read, ex_reg_write_en) are gated by valid. An empty EX forces them to 0, so r0 never matches a real hazard.
- Back-pressure: with valid=1 and mem_allow_in=0, contents hold and ex_allow_in=0.
- Back-to-back: if EX drains and ID delivers in the same cycle, EX reloads with no bubble.
- No state machine beyond the {valid, cnt} pair. States:
  - EMPTY: valid=0.
  - BUSY: valid=1, cnt>0.
  - DONE: valid=1, cnt=0.
- State transitions:
  - EMPTY→BUSY/DONE on Accept.
  - BUSY→DONE when cnt reaches 0.
  - DONE→EMPTY on drain without a new Accept.
  - Any state→EMPTY on flush.

Optional Feature:
- Macro: EX_PERF_CNT_EN.
- When defined, two extra output ports:
  - ex_stall_cycles (32): counts cycles with valid & ~ex_valid_out or valid & ex_valid_out & ~mem_allow_in.
  - ex_bubble_cycles (32): counts cycles with ~valid & ~ex_flush.
- Both counters reset to 0 on resetn and wrap at 2^32.
- When not defined, neither port nor counter exists and the behaviour above is unchanged.

Test Plan:
- Single-cycle flow: release reset, then id_valid_out=1, id_ready_go=1, mem_allow_in=1, rd=5, single-cycle → next cycle ex_valid_out=1, ex_rd_no=5, ex_allow_in=1.
- Multi-cycle (MC_LAT=4): accept an id_multicycle op → ex_busy=1 for 3 cycles, ex_allow_in=0 for those 3 cycles, ex_valid_out=1 on the 4th cycle after Accept.
- Flush mid-count: flush during a multi-cycle op after 1 cycle → next cycle valid=0, cnt=0, ex_rd_no=0, ex_allow_in=1; the in-flight op never appears on ex_valid_out.
- Simultaneous flush and accept: ex_flush=1 and id_valid_out=id_ready_go=1 in the same cycle with rd=7 → EX empty next cycle, ex_payload and ex_rd_no unchanged from before.
- Hold and bubble:
  - mem_allow_in=0 with EX holding rd=3 → ex_rd_no stays 3 and ex_allow_in=0 for 5 cycles.
  - Then id_ready_go=0 while mem_allow_in=1 → one bubble: ex_valid_out=0, ex_reg_write_en=0.
- Async reset: assert resetn=0 between clock edges while BUSY → outputs clear immediately, before the next edge; ex_allow_in=1.
